// File: rtl/spi_slv_pkg.sv
// Shared definitions for the SPI slave endpoint: FSM state encoding, byte
// width and the SPI-mode edge-select helper.
package spi_slv_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } spi_state_e;

  // Which synchronized SCK edge (rising/falling) samples MOSI and which shifts MISO.
  typedef struct packed {
    logic sample_on_rise;
    logic shift_on_rise;
  } edge_sel_t;

  // Leading edge is rising for CPOL=0. CPHA=0 samples on leading, CPHA=1 on trailing.
  function automatic edge_sel_t edge_sel(input logic cpol, input logic cpha);
    edge_sel_t sel;
    sel.sample_on_rise = ~(cpol ^ cpha);
    sel.shift_on_rise  = cpol ^ cpha;
    return sel;
  endfunction

endpackage

// File: rtl/spi_slv_fifo.sv
// Parameterized synchronous FIFO (DEPTH must be a power of two).
// A push on a full FIFO succeeds only when a pop happens in the same cycle.
module spi_slv_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == CNT_W'(0));
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];

  // Storage array and write pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
      r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
    end else begin
      r_wr_ptr <= r_wr_ptr;
    end
  end

  // Read pointer and occupancy count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI slave endpoint: oversamples SCK/MOSI/SS_N in the PCLK domain,
// deserializes MOSI into an RX FIFO and serializes TX bytes onto MISO.
// PCLK must be at least 8x the SCK frequency.
// Optional feature: define SPI_SLV_LSB_FIRST_EN for LSB-first shifting in
// both directions; default build is MSB-first.
module spi_slave_rx_tx
  import spi_slv_pkg::*;
#(
  parameter int               RX_DEPTH   = 4,
  parameter logic [BYTE_W-1:0] DUMMY_BYTE = 8'hFF,
  parameter bit               CPOL       = 1'b0,
  parameter bit               CPHA       = 1'b0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              sck_i,
  input  logic              mosi_i,
  input  logic              ss_n_i,
  output logic              miso_o,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic              busy
);

`ifdef SPI_SLV_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  localparam edge_sel_t EDGE = edge_sel(CPOL, CPHA);

  // Synchronizers and edge-detect history
  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_mosi_s1, r_mosi_s2;
  logic r_ss_s1, r_ss_s2, r_ss_s3;

  spi_state_e r_state;
  spi_state_e w_state_nxt;
  logic       w_do_load;
  logic       w_act;

  logic              w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;
  logic              w_sample_edge, w_shift_edge;
  logic              w_do_sample, w_shift_evt;
  logic              w_reload, w_tx_adv, w_tx_skip;
  logic [BYTE_W-1:0] w_next_byte;
  logic [BYTE_W-1:0] w_rx_next;
  logic              w_push, w_drop;
  logic              w_fifo_full, w_fifo_empty;
  logic [BYTE_W-1:0] w_fifo_head;

  logic [BYTE_W-1:0] r_tx_shift;
  logic [2:0]        r_tx_cnt;
  logic              r_first_skip;
  logic [BYTE_W-1:0] r_hold;
  logic              r_hold_empty;
  logic [BYTE_W-1:0] r_rx_shift;
  logic [2:0]        r_rx_cnt;
  logic              r_overrun;
  logic              r_busy;

  // Two-flop synchronizers plus a third flop for edge detection. SS_N history
  // resets low so that a select already held low at reset release is not
  // mistaken for a falling edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sck_s1  <= CPOL;
      r_sck_s2  <= CPOL;
      r_sck_s3  <= CPOL;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_ss_s1   <= 1'b0;
      r_ss_s2   <= 1'b0;
      r_ss_s3   <= 1'b0;
    end else begin
      r_sck_s1  <= sck_i;
      r_sck_s2  <= r_sck_s1;
      r_sck_s3  <= r_sck_s2;
      r_mosi_s1 <= mosi_i;
      r_mosi_s2 <= r_mosi_s1;
      r_ss_s1   <= ss_n_i;
      r_ss_s2   <= r_ss_s1;
      r_ss_s3   <= r_ss_s2;
    end
  end

  assign w_sck_rise    = r_sck_s2 & ~r_sck_s3;
  assign w_sck_fall    = ~r_sck_s2 & r_sck_s3;
  assign w_ss_fall     = ~r_ss_s2 & r_ss_s3;
  assign w_ss_rise     = r_ss_s2 & ~r_ss_s3;
  assign w_sample_edge = EDGE.sample_on_rise ? w_sck_rise : w_sck_fall;
  assign w_shift_edge  = EDGE.shift_on_rise ? w_sck_rise : w_sck_fall;

  // Frame state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle action qualifiers
  always_comb begin
    w_state_nxt = r_state;
    w_do_load   = 1'b0;
    w_act       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) w_state_nxt = LOAD;
        else           w_state_nxt = IDLE;
      end
      LOAD: begin
        w_do_load = 1'b1;
        if (w_ss_rise) w_state_nxt = IDLE;
        else           w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          w_act       = 1'b0;
        end else begin
          w_state_nxt = ACTIVE;
          w_act       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_do_sample = w_act & w_sample_edge;
  assign w_shift_evt = w_act & w_shift_edge;
  assign w_next_byte = r_hold_empty ? DUMMY_BYTE : r_hold;
  assign w_tx_skip   = w_shift_evt & r_first_skip;
  assign w_reload    = w_do_load | (w_shift_evt & ~r_first_skip & (r_tx_cnt == 3'd7));
  assign w_tx_adv    = w_shift_evt & ~r_first_skip & (r_tx_cnt != 3'd7);

  // TX shift register: load at frame start / byte boundary, otherwise shift.
  // With CPHA=1 the first leading edge is swallowed since LOAD already presents the first bit.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tx_shift   <= DUMMY_BYTE;
      r_tx_cnt     <= 3'd0;
      r_first_skip <= 1'b0;
    end else if (w_reload) begin
      r_tx_shift   <= w_next_byte;
      r_tx_cnt     <= 3'd0;
      r_first_skip <= w_do_load & CPHA;
    end else if (w_tx_skip) begin
      r_first_skip <= 1'b0;
    end else if (w_tx_adv) begin
      r_tx_shift <= LSB_FIRST ? {1'b0, r_tx_shift[BYTE_W-1:1]}
                              : {r_tx_shift[BYTE_W-2:0], 1'b0};
      r_tx_cnt   <= r_tx_cnt + 3'd1;
    end else begin
      r_tx_cnt <= r_tx_cnt;
    end
  end

  assign miso_o = LSB_FIRST ? r_tx_shift[0] : r_tx_shift[BYTE_W-1];

  // One-entry TX holding register: freed when its byte moves into the shifter
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_hold       <= '0;
      r_hold_empty <= 1'b1;
    end else if (w_reload && !r_hold_empty) begin
      r_hold_empty <= 1'b1;
    end else if (tx_valid && r_hold_empty) begin
      r_hold       <= tx_data;
      r_hold_empty <= 1'b0;
    end else begin
      r_hold_empty <= r_hold_empty;
    end
  end

  assign tx_ready = r_hold_empty;

  assign w_rx_next = LSB_FIRST ? {r_mosi_s2, r_rx_shift[BYTE_W-1:1]}
                               : {r_rx_shift[BYTE_W-2:0], r_mosi_s2};

  // RX deserializer; bit count restarts each frame so partial bytes are discarded
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rx_shift <= '0;
      r_rx_cnt   <= 3'd0;
    end else if (w_do_load) begin
      r_rx_cnt <= 3'd0;
    end else if (w_do_sample) begin
      r_rx_shift <= w_rx_next;
      r_rx_cnt   <= r_rx_cnt + 3'd1;
    end else begin
      r_rx_cnt <= r_rx_cnt;
    end
  end

  assign w_push = w_do_sample & (r_rx_cnt == 3'd7);
  assign w_drop = w_push & w_fifo_full & ~rx_ready;

  spi_slv_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (BYTE_W)
  ) u_rx_fifo (
    .i_clk       (PCLK),
    .i_rst_n     (PRESETn),
    .i_push      (w_push),
    .i_push_data (w_rx_next),
    .i_pop       (rx_ready),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign rx_data  = w_fifo_head;
  assign rx_valid = ~w_fifo_empty;

  // Sticky overrun flag; a new drop wins over a same-cycle clear
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign overrun = r_overrun;

  // Busy flag tracks whether a frame is in progress
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign busy = r_busy;

endmodule

// File: doc/spi_slave_rx_tx.md
Name: spi_slave_rx_tx

Overview:
- Synthesizable SPI slave endpoint on the far end of the simple_spi_top serial port.
- Consumes sck_o/mosi_o and produces miso_i.
- Oversamples the SPI lines in the PCLK domain, deserializes MOSI into a small RX FIFO, and serializes TX bytes onto MISO.
- Serves as the loopback/peer device for system-level SPI regression and as a reusable slave front-end.

Parameters:
- RX_DEPTH, 4: RX FIFO entries; power of two, 2..16.
- DUMMY_BYTE, 8'hFF: byte shifted out when no TX byte is pending at frame/byte start.
- CPOL, 0: idle level of sck_i.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  asynchronous active-low reset.
- sck_i  in  1  SPI clock from master, asynchronous to PCLK.
- mosi_i  in  1  master-out data.
- ss_n_i  in  1  active-low slave select.
- miso_o  out  1  slave-out data.
- rx_data  out  8  head of RX FIFO.
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  pop RX FIFO when rx_valid & rx_ready.
- tx_data  in  8  next byte to transmit.
- tx_valid  in  1  TX byte offered.
- tx_ready  out  1  TX holding register empty; accepted when tx_valid & tx_ready.
- overrun  out  1  sticky: received byte dropped because RX FIFO was full.
- clr_overrun  in  1  synchronous clear of overrun.
- busy  out  1  frame in progress (ss_n_i low, synchronized).

Behaviour:
- Interface: one clock PCLK; reset PRESETn is asynchronous, active-low.
- Reset values: miso_o = DUMMY_BYTE[7], rx_valid = 0, rx_data = 0, tx_ready = 1, overrun = 0, busy = 0. FIFO is emptied; bit counter = 0; state = IDLE.
- Synchronization: sck_i, mosi_i and ss_n_i each pass through a 2-flop synchronizer. Edges are detected on the synchronized sck by comparison with a 3rd flop.
  - Total latency from pin edge to action is 3 PCLK.
  - Requirement: PCLK ≥ 8× SCK frequency. At that ratio miso_o is stable ≥ 1 PCLK before the master's sample edge.
- Edge decoding: the leading edge is rising when CPOL = 0, falling when CPOL = 1.
  - CPHA = 0: sample = leading, shift = trailing.
  - CPHA = 1: shift = leading, sample = trailing.
- TX holding register (1 entry): loaded on the tx_valid & tx_ready handshake; tx_ready drops the next cycle.
- State machine:
  - IDLE: busy = 0. On synchronized ss_n falling → LOAD.
  - LOAD (1 cycle): shift register ← holding byte if full (holding freed, tx_ready = 1 next cycle), else DUMMY_BYTE. miso_o = bit 7. Bit counter = 0. → ACTIVE.
  - ACTIVE: busy = 1.
    - Sample edge: rx_shift ← {rx_shift[6:0], mosi}; bit counter + 1 (mod 8).
    - When the counter wraps 7→0, the completed byte is pushed to the RX FIFO. If the FIFO is full, the byte is dropped and overrun is set. A push and a pop in the same cycle on a full FIFO both succeed.
    - Shift edge: miso_o ← next tx bit.
    - After bit 7 has been shifted, the next shift edge reloads tx_shift from the holding register or DUMMY_BYTE, identical to LOAD.
    - CPHA = 1: the first leading edge of the frame does not advance tx, since bit 7 is already presented by LOAD.
    - Synchronized ss_n rising → IDLE.
- Partial byte at deselect (counter ≠ 0): received bits are discarded; no push. A TX byte already loaded into the shift register is consumed, not restored.
- miso_o holds its last value while ss_n is high; external tristating is outside this block.
- Priority: clr_overrun and a same-cycle overrun event → overrun stays set (set wins).
- PRESETn asserted mid-frame: immediate return to reset values. The frame restarts only on a fresh ss_n falling edge; a low ss_n at reset release does not start a frame.

Optional Feature:
- SPI_SLV_LSB_FIRST_EN defined: both shift registers operate LSB-first. LOAD presents bit 0; receive shifts right, {mosi, rx_shift[7:1]}.
- Undefined: MSB-first, as above. This matches the simple_spi master.

Decomposition:
- Shared package spi_slv_pkg: state enum (IDLE, LOAD, ACTIVE), BYTE_W = 8, edge-select helper function (cpol, cpha → sample/shift select).
- One sub-module: spi_slv_fifo, a parameterized synchronous FIFO with push/pop/full/empty. It is instantiated for RX.

Test Plan:
- Mode 0, master sends 8'hA5 with tx_data = 8'h3C preloaded → rx_data = 8'hA5, rx_valid = 1; master receives 8'h3C; tx_ready returns to 1 after LOAD.
- 3-byte frame 8'h01/8'h02/8'h03, tx_valid never asserted → RX FIFO pops 01, 02, 03 in order; master receives FF, FF, FF.
- RX_DEPTH = 4, rx_ready = 0, master sends 5 bytes → FIFO holds the first 4, overrun = 1. clr_overrun pulse → overrun = 0. A pop then yields byte 1.
- ss_n raised after 5 SCK edges of 8'hF0 → no push, rx_valid stays 0. The next full frame of 8'h55 → rx_data = 8'h55.
- Parameter sweep CPOL/CPHA ∈ {0,1}² at PCLK = 8× SCK, byte 8'hC3 both directions → exact match in all four modes.
- PRESETn pulsed mid-byte → all outputs at reset values. A subsequent frame of 8'h7E is received correctly; a build with SPI_SLV_LSB_FIRST_EN and an LSB-first master also yields 8'h7E.
